led_pattern_engine: RTL

- Parametrised LED pattern generator for the board top level. Successor to the fixed 4-LED, 2-speed pattern logic.
- Drives WIDTH LEDs with one of four patterns: blink, binary count, one-hot walk, thermometer fill/drain.
- Adds a multi-level speed select, a pause input, a step-strobe output and a proper synchronous reset.
- Sits between the board switches and the LED pins, clocked from the clock-wizard output.

---
 rtl/led_pattern_engine.sv | 135 +++++++++++++
 1 files changed

// File: rtl/led_pattern_engine.sv
// Parametrised LED pattern generator: blink, binary count, one-hot walk and
// thermometer fill/drain, with speed select, pause and a step strobe.
module led_pattern_engine #(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 50000000,
  parameter int SPEED_BITS = 2
) (
  input  logic                  HWClock,
  input  logic                  Reset,
  input  logic [1:0]            Mode,
  input  logic [SPEED_BITS-1:0] Speed,
  input  logic                  Dir,
  input  logic                  Pause,
  output logic [WIDTH-1:0]      LED,
  output logic                  StepTick
);

  typedef enum logic [1:0] {
    MODE_BLINK = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_FILL  = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] MSB_ONLY   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_ONLY   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]      TICK_DIV_W = 32'(TICK_DIV);

  mode_e            mode_in;
  mode_e            mode_q;
  mode_e            mode_d;
  logic [31:0]      prescaler_q;
  logic [31:0]      prescaler_d;
  logic [31:0]      period;
  logic [31:0]      period_m1;
  logic [WIDTH-1:0] led_d;
  logic [WIDTH-1:0] led_next;
  logic [WIDTH-1:0] led_inv;
  logic             tick_d;
  logic             is_zero;
  logic             all_ones;
  logic             is_onehot;
  logic             lsb_run;
  logic             msb_run;

  assign mode_in = mode_e'(Mode);

  // Period follows Speed every cycle; a shift to zero is clamped to one cycle.
  always_comb begin
    period = TICK_DIV_W >> Speed;
    if (period == '0) begin
      period = 32'd1;
    end
    period_m1 = period - 32'd1;
  end

  // Shape classification of the current LED value.
  always_comb begin
    led_inv   = ~LED;
    is_zero   = (LED == '0);
    all_ones  = (LED == '1);
    is_onehot = !is_zero && ((LED & (LED - LSB_ONLY)) == '0);
    lsb_run   = !is_zero && ((LED & (LED + LSB_ONLY)) == '0);
    msb_run   = !is_zero && ((led_inv & (led_inv + LSB_ONLY)) == '0);
  end

  always_comb begin
    led_next = '0;
    case (mode_q)
      MODE_BLINK: led_next = ~LED;
      MODE_COUNT: led_next = Dir ? (LED - LSB_ONLY) : (LED + LSB_ONLY);
      MODE_WALK: begin
        if (is_zero) begin
          led_next = Dir ? LSB_ONLY : MSB_ONLY;
        end else if (is_onehot) begin
          led_next = Dir ? (LED << 1) : (LED >> 1);
        end
      end
      MODE_FILL: begin
        // All-ones counts as both runs, so it falls through to the drain shift.
        if (is_zero) begin
          led_next = Dir ? LSB_ONLY : MSB_ONLY;
        end else if (!Dir) begin
          if (msb_run && !all_ones) begin
            led_next = (LED >> 1) | MSB_ONLY;
          end else if (lsb_run) begin
            led_next = LED >> 1;
          end
        end else begin
          if (lsb_run && !all_ones) begin
            led_next = (LED << 1) | LSB_ONLY;
          end else if (msb_run) begin
            led_next = LED << 1;
          end
        end
      end
      default: led_next = '0;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    prescaler_d = prescaler_q;
    led_d       = LED;
    tick_d      = 1'b0;
    if (mode_in != mode_q) begin
      mode_d      = mode_in;
      led_d       = '0;
      prescaler_d = '0;
    end else if (Pause) begin
      prescaler_d = prescaler_q;
    end else if (prescaler_q >= period_m1) begin
      prescaler_d = '0;
      led_d       = led_next;
      tick_d      = 1'b1;
    end else begin
      prescaler_d = prescaler_q + 32'd1;
    end
  end

  always_ff @(posedge HWClock) begin
    if (Reset) begin
      mode_q      <= mode_in;
      prescaler_q <= '0;
      LED         <= '0;
      StepTick    <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      prescaler_q <= prescaler_d;
      LED         <= led_d;
      StepTick    <= tick_d;
    end
  end

endmodule
